// File: rtl/mux4_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// rr_pick searches upward from a pointer, modulo 4.
package mux4_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Walk offsets from highest to lowest so the nearest candidate at or after ptr wins.
  function automatic rr_pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    rr_pick_t   res;
    logic [1:0] cand;
    res.found = 1'b0;
    res.idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 single-bit multiplexer used as the shared datapath.
module mux4 (
  input  logic [3:0] a,
  input  logic [1:0] s,
  output logic       y
);

  // Select one of four input bits
  always_comb begin
    y = 1'b0;
    case (s)
      2'd0:    y = a[0];
      2'd1:    y = a[1];
      2'd2:    y = a[2];
      2'd3:    y = a[3];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter owning the select of a shared 1-bit mux4.
// Grants are bounded by MAX_HOLD only while some other requester is waiting.
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] data,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       out_data,
  output logic       busy
);

  localparam int            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(32'd1);

  arb_state_t    state_r, state_s;
  logic [3:0]    grant_r, grant_s;
  logic [1:0]    sel_r, sel_s;
  logic [1:0]    ptr_r, ptr_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_s;
  logic          out_valid_r;
  logic          mux_y_s;
  logic [3:0]    others_s;
  logic [1:0]    ptr_inc_s;
  logic          release_s;
  rr_pick_t      pick_idle_s, pick_next_s;

  assign others_s    = req & ~grant_r;
  assign ptr_inc_s   = sel_r + 2'd1;
  assign pick_idle_s = rr_pick(req, ptr_r);
  assign pick_next_s = rr_pick(others_s, ptr_inc_s);
  assign release_s   = !req[sel_r] || ((hold_cnt_r == HOLD_MAX) && (|others_s));

  // Next-state, grant, pointer and hold-counter logic
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    sel_s      = sel_r;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_idle_s.found) begin
          state_s    = GRANT;
          grant_s    = idx_to_onehot(pick_idle_s.idx);
          sel_s      = pick_idle_s.idx;
          hold_cnt_s = HOLD_ONE;
        end else begin
          grant_s    = 4'b0000;
        end
      end
      GRANT: begin
        if (release_s) begin
          ptr_s = ptr_inc_s;
          // Handoff happens at the releasing edge so out_valid never drops.
          if (pick_next_s.found) begin
            state_s    = GRANT;
            grant_s    = idx_to_onehot(pick_next_s.idx);
            sel_s      = pick_next_s.idx;
            hold_cnt_s = HOLD_ONE;
          end else begin
            state_s    = IDLE;
            grant_s    = 4'b0000;
            hold_cnt_s = '0;
          end
        end else if (hold_cnt_r != HOLD_MAX) begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        grant_s    = 4'b0000;
        hold_cnt_s = '0;
      end
    endcase
  end

  // Arbiter state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grant_r     <= 4'b0000;
      sel_r       <= 2'd0;
      ptr_r       <= 2'd0;
      hold_cnt_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      sel_r       <= sel_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      out_valid_r <= (state_s == GRANT);
    end
  end

  mux4 u_mux4 (
    .a (data),
    .s (sel_r),
    .y (mux_y_s)
  );

  assign grant     = grant_r;
  assign sel       = sel_r;
  assign out_valid = out_valid_r;
  assign busy      = out_valid_r;
  assign out_data  = mux_y_s & out_valid_r;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed self-checking bench for mux4_arbiter with MAX_HOLD = 8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mux4_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_data;
  logic       busy;

  int errors;
  int checks;

  mux4_arbiter #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'h0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, ".out_data"}, 32'(out_data), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    req    = 4'hF;
    data   = 4'hF;

    // 1: reset with all requesting, then first grant to requester 0
    tick();
    chk_idle("rst1");
    chk("rst1.sel", 32'(sel), 32'h0);
    tick();
    chk_idle("rst2");
    rst_n = 1'b1;
    data  = 4'b1110;
    tick();
    chk("first.grant", 32'(grant), 32'h1);
    chk("first.sel", 32'(sel), 32'h0);
    chk("first.valid", 32'(out_valid), 32'h1);
    chk("first.busy", 32'(busy), 32'h1);
    chk("first.data", 32'(out_data), 32'h0);

    // 2: lone requester 2 held 20 cycles, data toggling
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("solo.grant", 32'(grant), 32'h4);
      chk("solo.sel", 32'(sel), 32'h2);
      data = (i % 2 == 0) ? 4'b0100 : 4'b1011;
      #1;
      chk("solo.data", 32'(out_data), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    req = 4'b0000;
    tick();
    chk_idle("solo.end");

    // 3: all four requesting, each holds exactly 8 cycles in order 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      for (int c = 0; c < 8; c++) begin
        chk("rr.grant", 32'(grant), 32'(exp_g));
        chk("rr.valid", 32'(out_valid), 32'h1);
        tick();
      end
    end

    // 4: owner 0 drops at its third cycle, handoff to 1 with a fresh hold count
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
    req   = 4'b0011;
    tick();
    chk("drop.g0", 32'(grant), 32'h1);
    tick();
    tick();
    chk("drop.g0b", 32'(grant), 32'h1);
    req = 4'b0010;
    tick();
    chk("drop.g1", 32'(grant), 32'h2);
    chk("drop.sel", 32'(sel), 32'h1);
    chk("drop.valid", 32'(out_valid), 32'h1);
    req = 4'b0011;
    for (int c = 1; c < 8; c++) begin
      tick();
      chk("drop.hold", 32'(grant), 32'h2);
    end
    tick();
    chk("drop.back0", 32'(grant), 32'h1);
    req  = 4'b0000;
    data = 4'hF;
    tick();
    chk_idle("drop.idle");

    // 6: no requests for 10 cycles with data all ones
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("noreq");
    end

    // 5: reset during an active grant of requester 2
    req = 4'b0100;
    tick();
    chk("rg.g2", 32'(grant), 32'h4);
    req = 4'b0101;
    tick();
    chk("rg.g2b", 32'(grant), 32'h4);
    rst_n = 1'b0;
    tick();
    chk_idle("rg.rst");
    chk("rg.sel", 32'(sel), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rg.g0", 32'(grant), 32'h1);
    chk("rg.sel0", 32'(sel), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
